// File: rtl/cv32e40p_cnn_postproc_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cv32e40p_cnn_postproc_if : handshake bundle for the CNN post-processing     |
// | stage (accumulator input side and quantized output side). Rev 1.0           |
// +----------------------------------------------------------------------------+
interface cv32e40p_cnn_postproc_if #(
  parameter int OUT_W = 32
);
  logic             clear_i;
  logic             relu_en_i;
  logic             acc_valid_i;
  logic             acc_ready_o;
  logic [31:0]      acc_data_i;
  logic [31:0]      bias_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [OUT_W-1:0] out_data_o;
  logic             busy_o;

  modport slave (
    input  clear_i, relu_en_i, acc_valid_i, acc_data_i, bias_i, out_ready_i,
    output acc_ready_o, out_valid_o, out_data_o, busy_o
  );

  modport master (
    output clear_i, relu_en_i, acc_valid_i, acc_data_i, bias_i, out_ready_i,
    input  acc_ready_o, out_valid_o, out_data_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/cv32e40p_cnn_postproc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cv32e40p_cnn_postproc : bias add + saturate, optional ReLU, 1-D max-pool,   |
// | shift requantization, valid/ready output. Rev 1.0                           |
// +----------------------------------------------------------------------------+
module cv32e40p_cnn_postproc #(
  parameter int POOL_N = 4,
  parameter int SHIFT  = 0,
  parameter int OUT_W  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_n_global_i,
  cv32e40p_cnn_postproc_if.slave  bus
);

  localparam int                       CNT_W    = (POOL_N > 1) ? $clog2(POOL_N) : 1;
  localparam logic [CNT_W-1:0]         LAST_CNT = CNT_W'(POOL_N - 1);
  localparam logic signed [OUT_W-1:0]  OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0]  OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

  logic                    s1_valid_q;
  logic signed [OUT_W-1:0] s1_data_q;
  logic [CNT_W-1:0]        pool_cnt_q;
  logic signed [OUT_W-1:0] pool_max_q;
  logic                    out_valid_q;
  logic signed [OUT_W-1:0] out_data_q;

  logic signed [32:0]      sum_d;
  logic signed [31:0]      clamp_d;
  logic signed [31:0]      relu_d;
  logic signed [31:0]      sh_d;
  logic [32-OUT_W:0]       sh_hi_d;
  logic signed [OUT_W-1:0] v_d;
  logic signed [OUT_W-1:0] win_d;
  logic                    last_d;
  logic                    pool_accept_d;
  logic                    acc_ready_d;
  logic                    in_xfer_d;

  // Requantization datapath: exact 33-bit add, clamp to 32, ReLU, shift, clamp to OUT_W.
  always_comb begin
    sum_d = $signed({bus.acc_data_i[31], bus.acc_data_i})
          + $signed({bus.bias_i[31], bus.bias_i});
    if (sum_d[32] != sum_d[31]) begin
      clamp_d = sum_d[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end else begin
      clamp_d = sum_d[31:0];
    end
    relu_d  = (bus.relu_en_i && clamp_d[31]) ? 32'sd0 : clamp_d;
    sh_d    = relu_d >>> SHIFT;
    sh_hi_d = sh_d[31:OUT_W-1];
    // Upper bits all equal to the sign means the value fits in OUT_W.
    if ((&sh_hi_d) || !(|sh_hi_d)) begin
      v_d = sh_d[OUT_W-1:0];
    end else begin
      v_d = sh_d[31] ? OUT_MIN : OUT_MAX;
    end
  end

  always_comb begin
    last_d        = (pool_cnt_q == LAST_CNT);
    pool_accept_d = s1_valid_q && (!last_d || !out_valid_q || bus.out_ready_i);
    acc_ready_d   = !s1_valid_q || pool_accept_d;
    in_xfer_d     = bus.acc_valid_i && acc_ready_d && !bus.clear_i;
    if ((POOL_N == 1) || (pool_cnt_q == '0)) begin
      win_d = s1_data_q;
    end else begin
      win_d = (s1_data_q > pool_max_q) ? s1_data_q : pool_max_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_global_i) begin
    if (!rst_n_global_i) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      pool_cnt_q  <= '0;
      pool_max_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (bus.clear_i) begin
      s1_valid_q  <= 1'b0;
      pool_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (in_xfer_d) begin
        s1_valid_q <= 1'b1;
        s1_data_q  <= v_d;
      end else if (pool_accept_d) begin
        s1_valid_q <= 1'b0;
      end

      if (pool_accept_d && !last_d) begin
        pool_max_q <= win_d;
        pool_cnt_q <= pool_cnt_q + CNT_W'(1);
      end

      // Loading a finished window takes precedence over the consumer draining it.
      if (pool_accept_d && last_d) begin
        out_data_q  <= win_d;
        out_valid_q <= 1'b1;
        pool_cnt_q  <= '0;
      end else if (out_valid_q && bus.out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.acc_ready_o = acc_ready_d;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.busy_o      = s1_valid_q || (pool_cnt_q != '0) || out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_cnn_postproc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cv32e40p_cnn_postproc : scoreboard bench for three parameterizations.    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_cv32e40p_cnn_postproc;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [15:0] q_c[$];

  cv32e40p_cnn_postproc_if #(.OUT_W(32)) ifa ();
  cv32e40p_cnn_postproc_if #(.OUT_W(32)) ifb ();
  cv32e40p_cnn_postproc_if #(.OUT_W(16)) ifc ();

  cv32e40p_cnn_postproc #(.POOL_N(1), .SHIFT(0), .OUT_W(32)) dut_a (
    .clk_i(clk), .rst_n_global_i(rst_n), .bus(ifa.slave));
  cv32e40p_cnn_postproc #(.POOL_N(4), .SHIFT(0), .OUT_W(32)) dut_b (
    .clk_i(clk), .rst_n_global_i(rst_n), .bus(ifb.slave));
  cv32e40p_cnn_postproc #(.POOL_N(1), .SHIFT(8), .OUT_W(16)) dut_c (
    .clk_i(clk), .rst_n_global_i(rst_n), .bus(ifc.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Scoreboard monitors: pop on every output transfer.
  always @(negedge clk) begin
    if (rst_n && ifa.out_valid_o && ifa.out_ready_i) begin
      if (q_a.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb_a_extra: got %h expected no output", ifa.out_data_o);
      end else chk("sb_a", ifa.out_data_o, q_a.pop_front());
    end
    if (rst_n && ifb.out_valid_o && ifb.out_ready_i) begin
      if (q_b.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb_b_extra: got %h expected no output", ifb.out_data_o);
      end else chk("sb_b", ifb.out_data_o, q_b.pop_front());
    end
    if (rst_n && ifc.out_valid_o && ifc.out_ready_i) begin
      if (q_c.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb_c_extra: got %h expected no output", ifc.out_data_o);
      end else chk("sb_c", {16'h0, ifc.out_data_o}, {16'h0, q_c.pop_front()});
    end
  end

  task automatic send_a(input logic [31:0] acc, input logic [31:0] bias, input logic relu,
                        input logic [31:0] exp);
    int guard = 0;
    ifa.acc_valid_i = 1'b1; ifa.acc_data_i = acc; ifa.bias_i = bias; ifa.relu_en_i = relu;
    q_a.push_back(exp);
    @(negedge clk);
    while (!ifa.acc_ready_o && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) begin n_cmp++; n_err++; $display("FAIL send_a_timeout: got ready=0 expected ready=1"); end
    @(posedge clk); #1;
    ifa.acc_valid_i = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] acc, input logic push, input logic [31:0] exp);
    int guard = 0;
    ifb.acc_valid_i = 1'b1; ifb.acc_data_i = acc; ifb.bias_i = 32'h0; ifb.relu_en_i = 1'b0;
    if (push) q_b.push_back(exp);
    @(negedge clk);
    while (!ifb.acc_ready_o && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) begin n_cmp++; n_err++; $display("FAIL send_b_timeout: got ready=0 expected ready=1"); end
    @(posedge clk); #1;
    ifb.acc_valid_i = 1'b0;
  endtask

  task automatic send_c(input logic [31:0] acc, input logic [15:0] exp);
    int guard = 0;
    ifc.acc_valid_i = 1'b1; ifc.acc_data_i = acc; ifc.bias_i = 32'h0; ifc.relu_en_i = 1'b0;
    q_c.push_back(exp);
    @(negedge clk);
    while (!ifc.acc_ready_o && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) begin n_cmp++; n_err++; $display("FAIL send_c_timeout: got ready=0 expected ready=1"); end
    @(posedge clk); #1;
    ifc.acc_valid_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ifa.clear_i = 0; ifa.relu_en_i = 0; ifa.acc_valid_i = 0; ifa.acc_data_i = 0; ifa.bias_i = 0; ifa.out_ready_i = 1;
    ifb.clear_i = 0; ifb.relu_en_i = 0; ifb.acc_valid_i = 0; ifb.acc_data_i = 0; ifb.bias_i = 0; ifb.out_ready_i = 1;
    ifc.clear_i = 0; ifc.relu_en_i = 0; ifc.acc_valid_i = 0; ifc.acc_data_i = 0; ifc.bias_i = 0; ifc.out_ready_i = 1;
    #3;
    chk1("rst_valid_a", ifa.out_valid_o, 1'b0);
    chk ("rst_data_a",  ifa.out_data_o, 32'h0);
    chk1("rst_busy_a",  ifa.busy_o, 1'b0);
    chk1("rst_ready_a", ifa.acc_ready_o, 1'b1);
    chk1("rst_busy_b",  ifb.busy_o, 1'b0);
    chk ("rst_data_c",  {16'h0, ifc.out_data_o}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic bias add with latency check.
    send_a(32'h0001_8000, 32'h0000_8000, 1'b1, 32'h0002_0000);
    chk1("lat_t0", ifa.out_valid_o, 1'b0);
    @(posedge clk); #1;
    chk1("lat_t1", ifa.out_valid_o, 1'b1);
    chk ("lat_t1_data", ifa.out_data_o, 32'h0002_0000);
    @(posedge clk); #1;
    chk1("lat_t2", ifa.out_valid_o, 1'b0);

    // ReLU and saturation, back to back.
    send_a(32'hFFFF_0000, 32'h0, 1'b1, 32'h0000_0000);
    send_a(32'hFFFF_0000, 32'h0, 1'b0, 32'hFFFF_0000);
    send_a(32'h7FFF_0000, 32'h0002_0000, 1'b0, 32'h7FFF_FFFF);
    send_a(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000);
    send_a(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000);
    repeat (4) @(posedge clk); #1;

    // Backpressure: three values with the consumer stalled.
    ifa.out_ready_i = 1'b0;
    send_a(32'h0011_0000, 32'h0, 1'b0, 32'h0011_0000);
    send_a(32'h0022_0000, 32'h0, 1'b0, 32'h0022_0000);
    ifa.acc_valid_i = 1'b1; ifa.acc_data_i = 32'h0033_0000; ifa.bias_i = 32'h0; ifa.relu_en_i = 1'b0;
    q_a.push_back(32'h0033_0000);
    repeat (2) @(negedge clk);
    chk1("bp_ready_low", ifa.acc_ready_o, 1'b0);
    chk1("bp_valid_hold", ifa.out_valid_o, 1'b1);
    chk ("bp_data_hold", ifa.out_data_o, 32'h0011_0000);
    @(posedge clk); #1;
    ifa.out_ready_i = 1'b1;
    @(negedge clk);
    chk1("bp_ready_up", ifa.acc_ready_o, 1'b1);
    chk1("bp_stream0", ifa.out_valid_o, 1'b1);
    @(posedge clk); #1;
    ifa.acc_valid_i = 1'b0;
    @(negedge clk);
    chk1("bp_stream1", ifa.out_valid_o, 1'b1);
    @(negedge clk);
    chk1("bp_stream2", ifa.out_valid_o, 1'b1);
    @(negedge clk);
    chk1("bp_stream_end", ifa.out_valid_o, 1'b0);

    // Max-pool window of four.
    @(posedge clk); #1;
    send_b(32'h0001_0000, 1'b0, 32'h0);
    chk1("pool_nov0", ifb.out_valid_o, 1'b0);
    send_b(32'h0003_0000, 1'b0, 32'h0);
    chk1("pool_nov1", ifb.out_valid_o, 1'b0);
    send_b(32'hFFFE_0000, 1'b0, 32'h0);
    chk1("pool_nov2", ifb.out_valid_o, 1'b0);
    send_b(32'h0002_8000, 1'b1, 32'h0003_0000);
    repeat (4) @(posedge clk); #1;

    // Clear mid-window discards the partial window.
    send_b(32'h0007_0000, 1'b0, 32'h0);
    send_b(32'h0009_0000, 1'b0, 32'h0);
    repeat (2) @(posedge clk); #1;
    chk1("clr_busy_pre", ifb.busy_o, 1'b1);
    ifb.clear_i = 1'b1;
    @(posedge clk); #1;
    ifb.clear_i = 1'b0;
    chk1("clr_busy_post", ifb.busy_o, 1'b0);
    chk ("clr_keep_data", ifb.out_data_o, 32'h0003_0000);
    for (int i = 0; i < 4; i++) send_b(32'h0005_0000, (i == 3), 32'h0005_0000);
    repeat (4) @(posedge clk); #1;

    // Reset mid-window behaves like clear.
    send_b(32'h0007_0000, 1'b0, 32'h0);
    send_b(32'h0009_0000, 1'b0, 32'h0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk1("rstmid_busy", ifb.busy_o, 1'b0);
    chk1("rstmid_ready", ifb.acc_ready_o, 1'b1);
    chk1("rstmid_valid", ifb.out_valid_o, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send_b(32'h0005_0000, (i == 3), 32'h0005_0000);
    repeat (4) @(posedge clk); #1;

    // Shift and narrow-output saturation.
    send_c(32'h0001_0000, 16'h0100);
    send_c(32'h0100_0000, 16'h7FFF);
    send_c(32'hFF00_0000, 16'h8000);
    send_c(32'hFFFF_8000, 16'hFF80);
    repeat (6) @(posedge clk); #1;

    chk("drain_a", q_a.size(), 32'd0);
    chk("drain_b", q_b.size(), 32'd0);
    chk("drain_c", q_c.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cv32e40p_cnn_postproc.md
Name: cv32e40p_cnn_postproc

Overview:
- Downstream stage of the Q16.16 multiply-accumulate unit in the CNN extension.
- Takes each finished dot-product sum and adds a bias, with saturation.
- Applies optional ReLU, then optional 1-D max-pool over POOL_N consecutive results.
- Requantizes by arithmetic shift plus saturation, and presents the result on a valid/ready output port for the writeback/store path.

Parameters:
- POOL_N, 4, values per max-pool window; 1 = pooling bypass; legal range 1..16.
- SHIFT, 0, arithmetic right shift applied before output saturation (Q16.16 -> coarser format).
- OUT_W, 32, output width in bits; signed; legal range 8..32.

Ports:
- clk_i  in  1  clock.
- rst_n_global_i  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous flush; drops all in-flight data.
- relu_en_i  in  1  ReLU enable; sampled with each accepted input.
- acc_valid_i  in  1  input sum valid.
- acc_ready_o  out  1  stage can accept input.
- acc_data_i  in  32  signed Q16.16 accumulated sum.
- bias_i  in  32  signed Q16.16 bias; sampled with acc_data_i.
- out_valid_o  out  1  output valid.
- out_ready_i  in  1  consumer ready.
- out_data_o  out  OUT_W  signed result.
- busy_o  out  1  s1_valid OR pool_cnt!=0 OR out_valid_o.

Behaviour:
- Reset (async, rst_n_global_i low):
  - s1_valid=0, pool_cnt=0, pool_max=0.
  - out_valid_o=0, out_data_o=0, busy_o=0, acc_ready_o=1.
- Input transfer: acc_valid_i && acc_ready_o on a rising edge.
- Stage S1 is loaded on input transfer with v, computed as:
  - sum = sign-extended 33-bit acc_data_i + bias_i;
  - clamp sum to [0x80000000, 0x7FFFFFFF];
  - if relu_en_i and result < 0, force result to 0;
  - sh = result >>> SHIFT;
  - v = sh clamped to the signed OUT_W range.
- Pool stage:
  - last = (pool_cnt == POOL_N-1).
  - pool_accept = s1_valid && (!last || !out_valid_o || out_ready_i).
  - On pool_accept with !last: pool_max <= (pool_cnt==0) ? v : max(pool_max, v); pool_cnt++.
  - On pool_accept with last: out_data_o <= (POOL_N==1 || pool_cnt==0) ? v : max(pool_max, v); out_valid_o <= 1; pool_cnt <= 0.
  - max is a signed compare.
- Ready/valid rules:
  - acc_ready_o = !s1_valid || pool_accept (combinational).
  - S1 empties on pool_accept unless refilled in the same cycle.
  - Simultaneous drain and refill is allowed; full throughput is 1 input per cycle.
- Output:
  - out_valid_o clears on out_valid_o && out_ready_i unless reloaded in the same cycle.
  - out_data_o and out_valid_o hold stable while out_valid_o && !out_ready_i.
- Latency, no stall: input accepted at edge T -> S1 valid after T -> element pooled at T+1. For POOL_N=1, out_valid_o is high after edge T+1.
- Ordering: windows are emitted strictly in order. No input is dropped or duplicated under any backpressure pattern.
- clear_i (has priority over all transfers that cycle):
  - next state: s1_valid=0, pool_cnt=0, out_valid_o=0;
  - out_data_o keeps its value;
  - acc_ready_o is still computed normally, but no input is captured that cycle.
- Reset mid-window: the partial window is discarded and the next input starts a fresh window.
- Widths: bias add is exact in 33 bits before the clamp. SHIFT=0 with OUT_W=32 is the identity after the clamp.

Test Plan:
- POOL_N=1, relu on, out_ready_i=1: acc=0x00018000, bias=0x00008000 -> out_data_o=0x00020000, out_valid_o high one cycle, after second edge following acceptance.
- POOL_N=1, acc=0xFFFF0000, bias=0:
  - relu on -> 0x00000000;
  - relu off -> 0xFFFF0000.
  - Saturation: acc=0x7FFF0000 + bias=0x00020000 -> 0x7FFFFFFF; acc=0x80000000 + bias=0xFFFFFFFF, relu off -> 0x80000000.
- POOL_N=4, back-to-back inputs 0x00010000, 0x00030000, 0xFFFE0000, 0x00028000 (bias 0, relu off) -> one output 0x00030000. out_valid_o is low during the first three inputs.
- POOL_N=1, out_ready_i=0 while streaming 3 values:
  - acc_ready_o falls after out and S1 are both full;
  - out_data_o holds the first value;
  - raising out_ready_i delivers all 3 in order, one per cycle, with no loss.
- SHIFT=8, OUT_W=16: acc=0x00010000 -> 0x0100; acc=0x01000000 -> 0x7FFF (saturated); acc=0xFF000000, relu off -> 0x8000.
- POOL_N=4: after 2 inputs, pulse clear_i, then send 0x00050000 ×4 -> single output 0x00050000 (pre-clear values ignored). Repeat with rst_n_global_i low for one cycle instead of clear_i -> same result, busy_o=0 immediately on reset.
